// File: rtl/gabor_conv_scheduler.sv
// Gabor conv scheduler: walks the window raster x orientation banks over one shared 5x5 datapath.
// Latency: SETTLE+1 cycles from win_ack (or the previous output handshake) to out_valid.
// Backpressure: result held and sequencing frozen while out_ready is low; waits indefinitely on win_ack.
module gabor_conv_scheduler #(
    parameter int  IMG_W      = 512,
    parameter int  IMG_H      = 512,
    parameter int  KERNEL     = 5,
    parameter int  NUM_ORIENT = 4,
    parameter int  RES_W      = 26,
    parameter int  SETTLE     = 2,
    parameter int  SUM_W      = RES_W + 3,
    localparam int OW         = (NUM_ORIENT > 1) ? $clog2(NUM_ORIENT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    win_req,
    output logic [15:0]             win_row,
    output logic [15:0]             win_col,
    input  logic                    win_ack,
    output logic [OW-1:0]           coeff_sel,
    input  logic signed [RES_W-1:0] res1,
    input  logic signed [RES_W-1:0] res2,
    input  logic signed [RES_W-1:0] res3,
    input  logic signed [RES_W-1:0] res4,
    input  logic signed [RES_W-1:0] res5,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [SUM_W-1:0] out_data,
    output logic [OW-1:0]           out_orient,
    output logic [15:0]             out_row,
    output logic [15:0]             out_col,
    output logic                    busy,
    output logic                    done
);
    localparam int            CW          = $clog2(SETTLE + 1);
    localparam logic [15:0]   COL_LAST    = 16'(IMG_W - KERNEL);
    localparam logic [15:0]   ROW_LAST    = 16'(IMG_H - KERNEL);
    localparam logic [OW-1:0] ORIENT_LAST = OW'(NUM_ORIENT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CAP, OUT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [15:0]             row, col;
    logic [CW-1:0]           settle_cnt;
    logic                    xfer, last_orient, last_win;
    logic signed [SUM_W-1:0] sum_c;

    assign xfer        = (state == OUT) && out_ready;
    assign last_orient = (coeff_sel == ORIENT_LAST);
    assign last_win    = (col == COL_LAST) && (row == ROW_LAST);
    assign sum_c       = SUM_W'(res1) + SUM_W'(res2) + SUM_W'(res3) + SUM_W'(res4) + SUM_W'(res5);

    assign win_req = (state == REQ);
    assign win_row = row;
    assign win_col = col;
    assign busy    = (state == REQ) || (state == WAIT) || (state == CAP) || (state == OUT);
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The CAP cycle is the last settle cycle, so WAIT lasts SETTLE-1 cycles (skipped when SETTLE==1).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ:  if (win_ack) state_nxt = (SETTLE > 1) ? WAIT : CAP;
            WAIT: if (settle_cnt == CW'(SETTLE - 2)) state_nxt = CAP;
            CAP:  state_nxt = OUT;
            OUT: begin
                if (out_ready) begin
                    if (!last_orient)   state_nxt = (SETTLE > 1) ? WAIT : CAP;
                    else if (!last_win) state_nxt = REQ;
                    else                state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            coeff_sel  <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_orient <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            if (state == IDLE && start) begin
                row <= '0;
                col <= '0;
            end
            if (state == REQ && win_ack) begin
                coeff_sel  <= '0;
                settle_cnt <= '0;
            end
            if (state == WAIT) settle_cnt <= settle_cnt + CW'(1);
            if (state == CAP) begin
                out_data   <= sum_c;
                out_orient <= coeff_sel;
                out_row    <= row;
                out_col    <= col;
                out_valid  <= 1'b1;
            end
            if (xfer) begin
                out_valid  <= 1'b0;
                settle_cnt <= '0;
                if (!last_orient) begin
                    coeff_sel <= coeff_sel + OW'(1);
                end else if (col != COL_LAST) begin
                    col <= col + 16'd1;
                end else if (row != ROW_LAST) begin
                    col <= '0;
                    row <= row + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gabor_conv_scheduler.sv
// Bench for gabor_conv_scheduler on a 7x6 image with two orientations.
// Latency: result order and sums checked through a scoreboard; hand sequences cover stall, latency, reset.
// Backpressure: out_ready and win_ack are held low or randomised to exercise both stall paths.
module tb_gabor_conv_scheduler;
    localparam int IMG_W      = 7;
    localparam int IMG_H      = 6;
    localparam int KERNEL     = 5;
    localparam int NUM_ORIENT = 2;
    localparam int RES_W      = 26;
    localparam int SETTLE     = 2;
    localparam int SUM_W      = 29;
    localparam int OW         = 1;
    localparam int NCOL       = IMG_W - KERNEL + 1;
    localparam int NROW       = IMG_H - KERNEL + 1;
    localparam int NRES       = NCOL * NROW * NUM_ORIENT;

    logic                    clk = 1'b0;
    logic                    rst_n, start, win_ack, out_ready;
    logic                    win_req, out_valid, busy, done;
    logic [15:0]             win_row, win_col, out_row, out_col;
    logic [OW-1:0]           coeff_sel, out_orient;
    logic signed [RES_W-1:0] res1, res2, res3, res4, res5;
    logic signed [SUM_W-1:0] out_data;

    typedef struct {
        logic signed [RES_W-1:0] r1, r2, r3, r4, r5;
        logic signed [SUM_W-1:0] sum;
    } vec_t;

    typedef struct {
        logic [15:0]             row, col;
        logic [OW-1:0]           orient;
        logic signed [SUM_W-1:0] data;
    } exp_t;

    vec_t vec[NRES];
    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    gabor_conv_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .NUM_ORIENT(NUM_ORIENT),
        .RES_W(RES_W), .SETTLE(SETTLE), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .win_req(win_req), .win_row(win_row), .win_col(win_col), .win_ack(win_ack),
        .coeff_sel(coeff_sel),
        .res1(res1), .res2(res2), .res3(res3), .res4(res4), .res5(res5),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_orient(out_orient), .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done)
    );

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e, input int s);
        vec_t v;
        v.r1 = RES_W'(a); v.r2 = RES_W'(b); v.r3 = RES_W'(c); v.r4 = RES_W'(d); v.r5 = RES_W'(e);
        v.sum = SUM_W'(s);
        return v;
    endfunction

    task automatic drive_res(input vec_t v);
        res1 = v.r1; res2 = v.r2; res3 = v.r3; res4 = v.r4; res5 = v.r5;
    endtask

    task automatic drive_rand_res();
        res1 = RES_W'($urandom); res2 = RES_W'($urandom); res3 = RES_W'($urandom);
        res4 = RES_W'($urandom); res5 = RES_W'($urandom);
    endtask

    // Result k of a frame: orientation innermost, then column, then row.
    task automatic push_exp(input int k, input vec_t v);
        exp_t e;
        e.orient = OW'(k % NUM_ORIENT);
        e.col    = 16'((k / NUM_ORIENT) % NCOL);
        e.row    = 16'((k / NUM_ORIENT) / NCOL);
        e.data   = v.sum;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_result: got row %0d col %0d orient %0d, expected no result",
                     out_row, out_col, out_orient);
        end else begin
            e = sb.pop_front();
            check("out_row", 64'(out_row), 64'(e.row));
            check("out_col", 64'(out_col), 64'(e.col));
            check("out_orient", 64'(out_orient), 64'(e.orient));
            check("out_data", 64'(out_data), 64'(e.data));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_win_req"}, 64'(win_req), 64'(0));
        check({tag, "_win_pos"}, 64'({win_row, win_col}), 64'(0));
        check({tag, "_coeff_sel"}, 64'(coeff_sel), 64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
        check({tag, "_out_meta"}, 64'({out_orient, out_row, out_col}), 64'(0));
        check({tag, "_busy_done"}, 64'({busy, done}), 64'(0));
    endtask

    // Full frame with the vector table; ack/ready given as percent-high, optional start noise while busy.
    task automatic run_frame(input int ack_pct, input int rdy_pct, input bit start_noise);
        int k, hs, dn, post;
        k = 0; hs = 0; dn = 0; post = 0;
        sb.delete();
        drive_res(vec[0]);
        push_exp(0, vec[0]);
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            win_ack   = ($urandom_range(99) < ack_pct);
            out_ready = ($urandom_range(99) < rdy_pct);
            start     = (start_noise && dn == 0) ? ($urandom_range(3) == 0) : 1'b0;
            #1;
            if (win_req && win_ack) hs++;
            if (done) dn++;
            if (out_valid && out_ready) begin
                pop_check();
                k++;
                if (k < NRES) begin
                    drive_res(vec[k]);
                    push_exp(k, vec[k]);
                end
            end
            if (dn > 0) post++;
            if (post >= 4) break;
        end
        start = 1'b0;
        check("frame_results", 64'(k), 64'(NRES));
        check("frame_win_handshakes", 64'(hs), 64'(NCOL * NROW));
        check("frame_done_pulses", 64'(dn), 64'(1));
        check("frame_scoreboard_left", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; win_ack = 1'b0; out_ready = 1'b0;
        vec[0]  = mk(-1, 2, 3, 4, 5, 13);
        vec[1]  = mk(-33554432, -33554432, -33554432, -33554432, -33554432, -167772160);
        vec[2]  = mk(33554431, 33554431, 33554431, 33554431, 33554431, 167772155);
        vec[3]  = mk(0, 0, 0, 0, 0, 0);
        vec[4]  = mk(100, -50, 25, -10, 1, 66);
        vec[5]  = mk(33554431, -33554432, 0, 0, 0, -1);
        vec[6]  = mk(1, 1, 1, 1, 1, 5);
        vec[7]  = mk(-7, 0, 0, 0, 0, -7);
        vec[8]  = mk(1000, 2000, 3000, 4000, 5000, 15000);
        vec[9]  = mk(-33554432, -33554432, 33554431, 33554431, 0, -2);
        vec[10] = mk(12345, -12345, 6789, 0, -1, 6788);
        vec[11] = mk(33554431, 33554431, 33554431, 33554431, -33554432, 100663292);
        drive_res(vec[3]);

        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Raster order, sums and done with win_ack tied high and no backpressure.
        run_frame(100, 100, 1'b0);

        // Fetch stall: win_ack held low for 7 cycles.
        sb.delete();
        @(negedge clk);
        win_ack = 1'b0; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("req_busy", 64'(busy), 64'(1));
        check("req_win_req", 64'(win_req), 64'(1));
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1;
            check("stall_win_req", 64'(win_req), 64'(1));
            check("stall_win_pos", 64'({win_row, win_col}), 64'(0));
            check("stall_coeff_sel", 64'(coeff_sel), 64'(1));
            check("stall_out_valid", 64'(out_valid), 64'(0));
        end

        // Latency: ack in cycle t, out_valid first high at t+3 with the CAP-cycle res.
        @(negedge clk);
        win_ack = 1'b1;
        drive_res(vec[3]);
        @(negedge clk);
        win_ack = 1'b0;
        #1;
        check("lat_t1_out_valid", 64'(out_valid), 64'(0));
        check("lat_t1_coeff_sel", 64'(coeff_sel), 64'(0));
        check("lat_t1_win_req", 64'(win_req), 64'(0));
        drive_res(vec[4]);
        @(negedge clk);
        #1;
        check("lat_t2_out_valid", 64'(out_valid), 64'(0));
        drive_res(vec[0]);
        push_exp(0, vec[0]);
        @(negedge clk);
        #1;
        check("lat_t3_out_valid", 64'(out_valid), 64'(1));
        pop_check();

        // Backpressure: 10 cycles with out_ready low while res wander.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_rand_res();
            #1;
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_out_data", 64'(out_data), 64'(13));
            check("bp_out_meta", 64'({out_orient, out_row, out_col}), 64'(0));
            check("bp_coeff_sel", 64'(coeff_sel), 64'(0));
            check("bp_win_req", 64'(win_req), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        drive_res(vec[2]);
        push_exp(1, vec[2]);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("bp_after_xfer_valid", 64'(out_valid), 64'(0));
        check("bp_after_xfer_coeff", 64'(coeff_sel), 64'(1));
        @(negedge clk);
        #1;
        check("bp_next_t2_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        #1;
        check("bp_next_t3_valid", 64'(out_valid), 64'(1));
        pop_check();

        // Asynchronous reset while a result is pending in OUT.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_idle_busy", 64'(busy), 64'(0));
        check("post_rst_idle_req", 64'(win_req), 64'(0));

        // Restart from (0,0,0) with random stalls and stray start pulses while busy.
        run_frame(70, 60, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
